memory_stage: RTL and testbench

- Y86-64 sequential-processor memory stage, directly downstream of execute.
- Consumes icode, valE, valA and valP; reads or writes a byte-addressed data memory; produces valM for writeback.
- Keeps a sticky processor status register (AOK/HLT/ADR/INS) that freezes architectural memory state once the machine stops.
- Also counts committed data-memory writes.

---
 rtl/memory_stage.sv | 131 +++++++++++++
 tb/tb_memory_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// =============================================================================
// memory_stage : Y86-64 memory stage, big-endian 8-byte data memory, sticky
//                processor status and committed-write counter.  Rev 1.0
// =============================================================================
module memory_stage #(
  parameter int MEM_BYTES = 65536,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       icode,
  input  logic             valid_memory,
  input  logic             valid_instruction,
  input  logic [63:0]      valE,
  input  logic [63:0]      valA,
  input  logic [63:0]      valP,
  output logic [63:0]      valM,
  output logic             dmem_error,
  output logic [1:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] wr_count
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_e;

  stat_e            stat_q, stat_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [7:0]       mem_q [MEM_BYTES];

  logic          rd_en;
  logic          wr_en;
  logic [63:0]   addr;
  logic [63:0]   wdata;
  logic [AW-1:0] base;
  logic [63:0]   rdata;
  logic          commit;

  // Access decode: which operand is the address and what gets stored.
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      I_MRMOVQ: rd_en = 1'b1;
      I_RET, I_POPQ: begin
        rd_en = 1'b1;
        addr  = valA;
      end
      I_RMMOVQ, I_PUSHQ: wr_en = 1'b1;
      I_CALL: begin
        wr_en = 1'b1;
        wdata = valP;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
  assign dmem_error = (rd_en || wr_en) && (addr > MAX_ADDR);
  assign base       = addr[AW-1:0];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[63-8*i -: 8] = mem_q[base + AW'(i)];
    end
    valM = (rd_en && !dmem_error && !reset) ? rdata : 64'd0;
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_q == S_AOK) begin
      if (!valid_memory)           stat_d = S_ADR;
      else if (!valid_instruction) stat_d = S_INS;
      else if (dmem_error)         stat_d = S_ADR;
      else if (icode == I_HALT)    stat_d = S_HLT;
      else                         stat_d = S_AOK;
    end
  end

  assign commit = wr_en && !dmem_error && !reset && (stat_q == S_AOK) &&
                  ((stat_d == S_AOK) || (stat_d == S_HLT));

  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q     <= S_AOK;
      wr_count_q <= '0;
    end else begin
      stat_q     <= stat_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[base + AW'(i)] <= wdata[63-8*i -: 8];
      end
    end
  end

  assign stat     = stat_q;
  assign halted   = (stat_q != S_AOK);
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// =============================================================================
// tb_memory_stage : directed self-checking bench for memory_stage.  Rev 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_memory_stage;

  localparam int MEM_BYTES = 65536;
  localparam int CNT_W     = 32;

  logic             clk;
  logic             reset;
  logic [3:0]       icode;
  logic             valid_memory;
  logic             valid_instruction;
  logic [63:0]      valE;
  logic [63:0]      valA;
  logic [63:0]      valP;
  logic [63:0]      valM;
  logic             dmem_error;
  logic [1:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] wr_count;

  int n_total = 0;
  int n_bad   = 0;

  memory_stage #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .icode            (icode),
    .valid_memory     (valid_memory),
    .valid_instruction(valid_instruction),
    .valE             (valE),
    .valA             (valA),
    .valP             (valP),
    .valM             (valM),
    .dmem_error       (dmem_error),
    .stat             (stat),
    .halted           (halted),
    .wr_count         (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    icode = ic;
    valE  = e;
    valA  = a;
    valP  = p;
    #1;
  endtask

  // One rising edge; outputs sampled 1ns afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'h1, 64'd0, 64'd0, 64'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    valid_memory      = 1'b1;
    valid_instruction = 1'b1;
    drive(4'h5, 64'd100, 64'd0, 64'd0);
    tick();
    tick();
    check("rst_stat", 64'(stat), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_wrcnt", 64'(wr_count), 64'd0);
    check("rst_valM", valM, 64'd0);
    reset = 1'b0;

    // rmmovq then mrmovq
    drive(4'h4, 64'd100, 64'h0102030405060708, 64'd0);
    check("rm_dmem_err", 64'(dmem_error), 64'd0);
    tick();
    check("rm_wrcnt", 64'(wr_count), 64'd1);
    drive(4'h5, 64'd100, 64'd0, 64'd0);
    check("mr_valM", valM, 64'h0102030405060708);
    check("m100", 64'(dut.mem_q[100]), 64'h01);
    check("m107", 64'(dut.mem_q[107]), 64'h08);

    // call/ret, pushq/popq
    drive(4'h8, 64'd200, 64'd0, 64'd77);
    tick();
    drive(4'h9, 64'd0, 64'd200, 64'd0);
    check("ret_valM", valM, 64'd77);
    drive(4'hA, 64'd300, 64'd5, 64'd0);
    tick();
    drive(4'hB, 64'd0, 64'd300, 64'd0);
    check("pop_valM", valM, 64'd5);
    check("pp_wrcnt", 64'(wr_count), 64'd3);

    // no access: huge address must not flag, valM zero
    drive(4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    check("nop_dmem_err", 64'(dmem_error), 64'd0);
    check("nop_valM", valM, 64'd0);

    // range boundary
    drive(4'h4, 64'(MEM_BYTES - 8), 64'hCAFE_BABE_1234_5678, 64'd0);
    check("top_dmem_err", 64'(dmem_error), 64'd0);
    tick();
    check("top_stat", 64'(stat), 64'd0);
    check("top_wrcnt", 64'(wr_count), 64'd4);
    drive(4'h5, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
    check("top_valM", valM, 64'hCAFE_BABE_1234_5678);
    drive(4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    check("max_dmem_err", 64'(dmem_error), 64'd1);
    drive(4'h5, 64'(MEM_BYTES - 7), 64'd0, 64'd0);
    check("oor_rd_err", 64'(dmem_error), 64'd1);
    check("oor_valM", valM, 64'd0);
    drive(4'h4, 64'(MEM_BYTES - 7), 64'h1111_1111_1111_1111, 64'd0);
    check("oor_wr_err", 64'(dmem_error), 64'd1);
    tick();
    check("oor_stat", 64'(stat), 64'd2);
    check("oor_halted", 64'(halted), 64'd1);
    check("oor_wrcnt", 64'(wr_count), 64'd4);
    drive(4'h5, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
    check("oor_keep", valM, 64'hCAFE_BABE_1234_5678);

    // halt then sticky
    do_reset();
    check("r2_stat", 64'(stat), 64'd0);
    drive(4'h4, 64'd8, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0);
    tick();
    check("pre_wrcnt", 64'(wr_count), 64'd1);
    drive(4'h0, 64'd0, 64'd0, 64'd0);
    check("halt_valM", valM, 64'd0);
    tick();
    check("halt_stat", 64'(stat), 64'd1);
    check("halt_halted", 64'(halted), 64'd1);
    drive(4'h4, 64'd8, 64'd9, 64'd0);
    tick();
    check("sticky_stat", 64'(stat), 64'd1);
    check("sticky_wrcnt", 64'(wr_count), 64'd1);
    drive(4'h5, 64'd8, 64'd0, 64'd0);
    check("sticky_mem", valM, 64'hAAAA_BBBB_CCCC_DDDD);

    // status priority
    do_reset();
    valid_memory      = 1'b0;
    valid_instruction = 1'b0;
    drive(4'h1, 64'd0, 64'd0, 64'd0);
    tick();
    check("prio_adr", 64'(stat), 64'd2);
    valid_memory      = 1'b1;
    valid_instruction = 1'b1;
    do_reset();
    drive(4'h4, 64'd16, 64'h1111_2222_3333_4444, 64'd0);
    tick();
    valid_instruction = 1'b0;
    drive(4'h4, 64'd16, 64'h55, 64'd0);
    tick();
    valid_instruction = 1'b1;
    check("prio_ins", 64'(stat), 64'd3);
    check("ins_wrcnt", 64'(wr_count), 64'd1);
    drive(4'h5, 64'd16, 64'd0, 64'd0);
    check("ins_mem", valM, 64'h1111_2222_3333_4444);

    // reset mid-run, coinciding with a write
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'h4, 64'(400 + 8 * i), 64'(64'h1000 + i), 64'd0);
      tick();
    end
    drive(4'h4, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0);
    tick();
    check("mid_wrcnt", 64'(wr_count), 64'd3);
    check("mid_stat", 64'(stat), 64'd2);
    reset = 1'b1;
    drive(4'h4, 64'd400, 64'hDEAD, 64'd0);
    tick();
    reset = 1'b0;
    check("mid_rst_stat", 64'(stat), 64'd0);
    check("mid_rst_wrcnt", 64'(wr_count), 64'd0);
    drive(4'h5, 64'd400, 64'd0, 64'd0);
    check("mid_mem0", valM, 64'h1000);
    drive(4'h5, 64'd416, 64'd0, 64'd0);
    check("mid_mem2", valM, 64'h1002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
